// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-requester SRAM port arbiter: bus widths, FSM
// state encoding and requester identifiers.
package sram_arbiter_pkg;

   localparam int ADDR_W = 21;
   localparam int DATA_W = 32;
   localparam int WE_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } req_id_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selection between M0 and M1.
// Round-robin (ARB_MODE=0) favours the requester not served last; fixed (1) always favours M1.
module sram_arb_pick
   import sram_arbiter_pkg::*;
#(
   parameter int ARB_MODE = 0
) (
   input  logic [1:0] req_i,
   input  req_id_t    last_i,
   output req_id_t    grant_o
);

   always_comb begin
      grant_o = M0;
      if (ARB_MODE == 1) begin
         if (req_i[1]) grant_o = M1;
      end else begin
         if (req_i == 2'b11) begin
            grant_o = (last_i == M0) ? M1 : M0;
         end else if (req_i[1]) begin
            grant_o = M1;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller port between instruction fetch (M0) and data (M1),
// one whole transaction at a time, with a mandatory idle cycle and a watchdog.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ARB_MODE = 0,
   parameter int TIMEOUT  = 15,
   parameter int TO_W     = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [WE_W-1:0]   i_m0_we,
   input  logic [DATA_W-1:0] i_m0_dat_w,
   input  logic              i_m0_stb,
   output logic [DATA_W-1:0] o_m0_dat_r,
   output logic              o_m0_ack,
   output logic              o_m0_err,
   input  logic [ADDR_W-1:0] i_m1_addr,
   input  logic [WE_W-1:0]   i_m1_we,
   input  logic [DATA_W-1:0] i_m1_dat_w,
   input  logic              i_m1_stb,
   output logic [DATA_W-1:0] o_m1_dat_r,
   output logic              o_m1_ack,
   output logic              o_m1_err,
   output logic [ADDR_W-1:0] o_s_addr,
   output logic [WE_W-1:0]   o_s_we,
   output logic [DATA_W-1:0] o_s_dat_w,
   output logic              o_s_stb,
   input  logic [DATA_W-1:0] i_s_dat_r,
   input  logic              i_s_ack
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   if ((TIMEOUT < 4) || (TIMEOUT >= (1 << TO_W))) begin : g_bad_timeout
      $error("sram_arbiter: TIMEOUT must be >= 4 and fit in TO_W bits");
   end

   state_t          state_q, state_d;
   req_id_t         grant_q, grant_d;
   req_id_t         last_q,  last_d;
   logic [TO_W-1:0] cnt_q,   cnt_d;

   req_id_t         pick;
   logic            gnt_stb;
   logic            ack_ok;
   logic            to_hit;
   logic            done;

   sram_arb_pick #(
      .ARB_MODE (ARB_MODE)
   ) u_pick (
      .req_i   ({i_m1_stb, i_m0_stb}),
      .last_i  (last_q),
      .grant_o (pick)
   );

   assign gnt_stb = (grant_q == M1) ? i_m1_stb : i_m0_stb;
   assign ack_ok  = (state_q == ST_GRANT) && i_s_ack;
   assign to_hit  = (state_q == ST_GRANT) && !i_s_ack && (cnt_q == TO_LAST);
   assign done    = ack_ok || to_hit;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= M0;
         last_q  <= M0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_m0_stb || i_m1_stb) begin
               grant_d = pick;
               cnt_d   = '0;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (done) begin
               last_d  = grant_q;
               state_d = ST_GAP;
            end else if (cnt_q != {TO_W{1'b1}}) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Requests are deliberately ignored here so a just-acked strobe is never re-granted.
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_s_stb    = 1'b0;
      o_s_addr   = '0;
      o_s_we     = '0;
      o_s_dat_w  = '0;
      o_m0_ack   = 1'b0;
      o_m0_err   = 1'b0;
      o_m0_dat_r = '0;
      o_m1_ack   = 1'b0;
      o_m1_err   = 1'b0;
      o_m1_dat_r = '0;
      if (state_q == ST_GRANT) begin
         o_s_stb   = 1'b1;
         o_s_addr  = (grant_q == M1) ? i_m1_addr  : i_m0_addr;
         o_s_we    = (grant_q == M1) ? i_m1_we    : i_m0_we;
         o_s_dat_w = (grant_q == M1) ? i_m1_dat_w : i_m0_dat_w;
      end
      // A reset landing on the completing cycle abandons the transaction silently.
      if (done && i_rst_n) begin
         if (grant_q == M1) begin
            o_m1_ack   = 1'b1;
            o_m1_err   = to_hit;
            o_m1_dat_r = ack_ok ? i_s_dat_r : '0;
         end else begin
            o_m0_ack   = 1'b1;
            o_m0_err   = to_hit;
            o_m0_dat_r = ack_ok ? i_s_dat_r : '0;
         end
      end
   end

   a_granted_stb_held : assert property (
      @(posedge i_clk) disable iff (!i_rst_n) (state_q == ST_GRANT) |-> gnt_stb
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: round-robin (u_rr) and fixed-priority (u_fx) instances
// share stimulus; the instance not under test is held in reset.
module tb_sram_arbiter;

   localparam int TIMEOUT = 15;
   localparam logic [20:0] A0 = 21'h00010;
   localparam logic [20:0] A1 = 21'h1ABCD;
   localparam logic [31:0] D0 = 32'h11111111;
   localparam logic [31:0] D1 = 32'h22222222;

   logic        clk = 1'b0;
   logic        rst0_n, rst1_n;
   logic [20:0] m0_addr, m1_addr;
   logic [3:0]  m0_we, m1_we;
   logic [31:0] m0_dat_w, m1_dat_w;
   logic        m0_stb, m1_stb;
   logic [31:0] s_dat_r;
   logic        s_ack;

   logic        s_stb_o [2];
   logic [3:0]  s_we_o [2];
   logic [20:0] s_addr_o [2];
   logic [31:0] s_dw_o [2];
   logic        m0_ack_o [2];
   logic        m0_err_o [2];
   logic [31:0] m0_dr_o [2];
   logic        m1_ack_o [2];
   logic        m1_err_o [2];
   logic [31:0] m1_dr_o [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.ARB_MODE(0), .TIMEOUT(TIMEOUT), .TO_W(4)) u_rr (
      .i_clk(clk), .i_rst_n(rst0_n),
      .i_m0_addr(m0_addr), .i_m0_we(m0_we), .i_m0_dat_w(m0_dat_w), .i_m0_stb(m0_stb),
      .o_m0_dat_r(m0_dr_o[0]), .o_m0_ack(m0_ack_o[0]), .o_m0_err(m0_err_o[0]),
      .i_m1_addr(m1_addr), .i_m1_we(m1_we), .i_m1_dat_w(m1_dat_w), .i_m1_stb(m1_stb),
      .o_m1_dat_r(m1_dr_o[0]), .o_m1_ack(m1_ack_o[0]), .o_m1_err(m1_err_o[0]),
      .o_s_addr(s_addr_o[0]), .o_s_we(s_we_o[0]), .o_s_dat_w(s_dw_o[0]), .o_s_stb(s_stb_o[0]),
      .i_s_dat_r(s_dat_r), .i_s_ack(s_ack)
   );

   sram_arbiter #(.ARB_MODE(1), .TIMEOUT(TIMEOUT), .TO_W(4)) u_fx (
      .i_clk(clk), .i_rst_n(rst1_n),
      .i_m0_addr(m0_addr), .i_m0_we(m0_we), .i_m0_dat_w(m0_dat_w), .i_m0_stb(m0_stb),
      .o_m0_dat_r(m0_dr_o[1]), .o_m0_ack(m0_ack_o[1]), .o_m0_err(m0_err_o[1]),
      .i_m1_addr(m1_addr), .i_m1_we(m1_we), .i_m1_dat_w(m1_dat_w), .i_m1_stb(m1_stb),
      .o_m1_dat_r(m1_dr_o[1]), .o_m1_ack(m1_ack_o[1]), .o_m1_err(m1_err_o[1]),
      .o_s_addr(s_addr_o[1]), .o_s_we(s_we_o[1]), .o_s_dat_w(s_dw_o[1]), .o_s_stb(s_stb_o[1]),
      .i_s_dat_r(s_dat_r), .i_s_ack(s_ack)
   );

   typedef struct {
      logic        rst;
      logic        s0;
      logic        s1;
      logic [3:0]  we1;
      logic        ack;
      logic [31:0] sdat;
      logic        e_stb;
      logic [3:0]  e_we;
      logic [20:0] e_addr;
      logic        a0;
      logic        a1;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic rst, input logic s0, input logic s1, input logic [3:0] we1,
                               input logic ack, input logic [31:0] sdat, input logic e_stb,
                               input logic [3:0] e_we, input logic [20:0] e_addr,
                               input logic a0, input logic a1);
      vec_t v;
      v.rst = rst; v.s0 = s0; v.s1 = s1; v.we1 = we1; v.ack = ack; v.sdat = sdat;
      v.e_stb = e_stb; v.e_we = e_we; v.e_addr = e_addr; v.a0 = a0; v.a1 = a1;
      tbl.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_all(input int d, input string tag, input logic e_stb, input logic [3:0] e_we,
                          input logic [20:0] e_addr, input logic [31:0] e_dw,
                          input logic a0, input logic e0, input logic [31:0] d0,
                          input logic a1, input logic e1, input logic [31:0] d1);
      chk({tag, ".s_stb"},   32'(s_stb_o[d]),  32'(e_stb));
      chk({tag, ".s_we"},    32'(s_we_o[d]),   32'(e_we));
      chk({tag, ".s_addr"},  32'(s_addr_o[d]), 32'(e_addr));
      chk({tag, ".s_dat_w"}, s_dw_o[d],        e_dw);
      chk({tag, ".m0_ack"},  32'(m0_ack_o[d]), 32'(a0));
      chk({tag, ".m0_err"},  32'(m0_err_o[d]), 32'(e0));
      chk({tag, ".m0_dat"},  m0_dr_o[d],       d0);
      chk({tag, ".m1_ack"},  32'(m1_ack_o[d]), 32'(a1));
      chk({tag, ".m1_err"},  32'(m1_err_o[d]), 32'(e1));
      chk({tag, ".m1_dat"},  m1_dr_o[d],       d1);
   endtask

   task automatic drive(input logic s0, input logic s1, input logic [3:0] we1,
                        input logic ack, input logic [31:0] sd);
      m0_addr = A0; m0_we = 4'h0; m0_dat_w = D0; m0_stb = s0;
      m1_addr = A1; m1_we = we1;  m1_dat_w = D1; m1_stb = s1;
      s_ack = ack; s_dat_r = sd;
   endtask

   // Expected slave-side write data follows whichever fixed address is granted.
   function automatic logic [31:0] dw_of(input logic e_stb, input logic [20:0] e_addr);
      if (!e_stb) return 32'h0;
      return (e_addr == A0) ? D0 : D1;
   endfunction

   task automatic reset_dut(input int d);
      rst0_n = 1'b0; rst1_n = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
      tick(); tick();
      rst0_n = (d == 0); rst1_n = (d == 1);
   endtask

   task automatic run_random(input int mode, input int ncyc);
      int          owner, gcyc, last;
      bit          cool, end_now, err;
      bit          rq[2], drop[2];
      logic [20:0] ad[2];
      logic [3:0]  we[2];
      logic [31:0] dw[2];
      logic        e_stb, ea[2], ee[2];
      logic [3:0]  e_we;
      logic [20:0] e_addr;
      logic [31:0] e_dw, ed[2], sd;
      logic        ack;
      int          pct;
      reset_dut(mode);
      owner = -1; gcyc = 0; last = 0; cool = 1'b0;
      for (int r = 0; r < 2; r++) begin
         rq[r] = 1'b0; drop[r] = 1'b0; ad[r] = '0; we[r] = '0; dw[r] = '0;
      end
      for (int i = 0; i < ncyc; i++) begin
         for (int r = 0; r < 2; r++) begin
            if (drop[r]) begin
               rq[r] = 1'b0; drop[r] = 1'b0;
            end else if (!rq[r] && $urandom_range(0, 2) == 0) begin
               rq[r] = 1'b1;
               ad[r] = 21'($urandom);
               we[r] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
               dw[r] = $urandom;
            end
         end
         pct = ((i / 150) % 2 == 1) ? 2 : 40;
         ack = ($urandom_range(0, 99) < pct);
         sd  = $urandom;
         m0_addr = ad[0]; m0_we = we[0]; m0_dat_w = dw[0]; m0_stb = rq[0];
         m1_addr = ad[1]; m1_we = we[1]; m1_dat_w = dw[1]; m1_stb = rq[1];
         s_ack = ack; s_dat_r = sd;

         e_stb = 1'b0; e_we = '0; e_addr = '0; e_dw = '0;
         ea[0] = 1'b0; ea[1] = 1'b0; ee[0] = 1'b0; ee[1] = 1'b0; ed[0] = '0; ed[1] = '0;
         end_now = 1'b0; err = 1'b0;
         if (owner >= 0) begin
            e_stb = 1'b1; e_we = we[owner]; e_addr = ad[owner]; e_dw = dw[owner];
            if (ack) end_now = 1'b1;
            else if (gcyc == TIMEOUT) begin end_now = 1'b1; err = 1'b1; end
            if (end_now) begin
               ea[owner] = 1'b1; ee[owner] = err; ed[owner] = err ? 32'h0 : sd;
            end
         end
         @(negedge clk);
         cmp_all(mode, $sformatf("rnd%0d[%0d]", mode, i), e_stb, e_we, e_addr, e_dw,
                 ea[0], ee[0], ed[0], ea[1], ee[1], ed[1]);

         if (owner >= 0) begin
            if (end_now) begin
               last = owner; drop[owner] = 1'b1; owner = -1; cool = 1'b1;
            end else begin
               gcyc++;
            end
         end else if (cool) begin
            cool = 1'b0;
         end else if (rq[0] || rq[1]) begin
            if (mode == 1)           owner = rq[1] ? 1 : 0;
            else if (rq[0] && rq[1]) owner = 1 - last;
            else                     owner = rq[1] ? 1 : 0;
            gcyc = 1;
         end
         tick();
      end
   endtask

   initial begin
      rst0_n = 1'b0; rst1_n = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);

      //   rst s0 s1 we1   ack sdat          stb we    addr a0 a1
      add(0, 1, 1, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(0, 1, 1, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(0, 1, 1, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 1, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 1, 4'h0, 0, 32'h0,        1, 4'h0, A1, 0, 0);
      add(1, 1, 1, 4'h0, 1, 32'hCAFEF00D, 1, 4'h0, A1, 0, 1);
      add(1, 1, 0, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 1, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 1, 4'h0, 0, 32'h0,        1, 4'h0, A0, 0, 0);
      add(1, 1, 1, 4'h0, 1, 32'hDEADBEEF, 1, 4'h0, A0, 1, 0);
      add(1, 0, 1, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 1, 4'hF, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 1, 4'hF, 0, 32'h0,        1, 4'hF, A1, 0, 0);
      add(1, 1, 1, 4'hF, 0, 32'h0,        1, 4'hF, A1, 0, 0);
      add(1, 1, 1, 4'hF, 0, 32'h0,        1, 4'hF, A1, 0, 0);
      add(1, 1, 1, 4'hF, 1, 32'h12345678, 1, 4'hF, A1, 0, 1);
      add(1, 1, 0, 4'h0, 1, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 0, 4'h0, 1, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 1, 4'h0, 1, 32'hA5A5A5A5, 1, 4'h0, A0, 1, 0);
      add(1, 0, 1, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 0, 1, 4'hF, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 0, 1, 4'hF, 0, 32'h0,        1, 4'hF, A1, 0, 0);
      add(0, 0, 1, 4'hF, 0, 32'h0,        1, 4'hF, A1, 0, 0);
      add(1, 0, 1, 4'hF, 1, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 1, 4'hF, 1, 32'h0BADF00D, 1, 4'hF, A1, 0, 1);
      add(1, 1, 0, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 0, 4'h0, 0, 32'h0,        0, 4'h0, '0, 0, 0);
      add(1, 1, 0, 4'h0, 0, 32'h0,        1, 4'h0, A0, 0, 0);

      foreach (tbl[i]) begin
         rst0_n = tbl[i].rst;
         drive(tbl[i].s0, tbl[i].s1, tbl[i].we1, tbl[i].ack, tbl[i].sdat);
         @(negedge clk);
         cmp_all(0, $sformatf("tbl[%0d]", i), tbl[i].e_stb, tbl[i].e_we, tbl[i].e_addr,
                 dw_of(tbl[i].e_stb, tbl[i].e_addr),
                 tbl[i].a0, 1'b0, tbl[i].a0 ? tbl[i].sdat : 32'h0,
                 tbl[i].a1, 1'b0, tbl[i].a1 ? tbl[i].sdat : 32'h0);
         tick();
      end

      // Watchdog: M1 never acked, terminated with error on its 15th granted cycle.
      reset_dut(0);
      drive(1'b0, 1'b1, 4'h0, 1'b0, 32'hFFFFFFFF);
      @(negedge clk);
      cmp_all(0, "to.idle", 1'b0, 4'h0, '0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      tick();
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(negedge clk);
         cmp_all(0, $sformatf("to.g%0d", k), 1'b1, 4'h0, A1, D1, 0, 0, 32'h0,
                 k == TIMEOUT, k == TIMEOUT, 32'h0);
         tick();
      end
      drive(1'b1, 1'b0, 4'h0, 1'b0, 32'hFFFFFFFF);
      @(negedge clk);
      cmp_all(0, "to.gap", 1'b0, 4'h0, '0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      tick();
      @(negedge clk);
      cmp_all(0, "to.idle2", 1'b0, 4'h0, '0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 4'h0, 1'b1, 32'h600DF00D);
      @(negedge clk);
      cmp_all(0, "to.next", 1'b1, 4'h0, A0, D0, 1, 0, 32'h600DF00D, 0, 0, 32'h0);
      tick();

      // Fixed priority: M1 wins every round while it keeps requesting.
      reset_dut(1);
      for (int r = 0; r < 3; r++) begin
         drive(1'b1, 1'b1, 4'h3, 1'b0, 32'h0);
         @(negedge clk);
         cmp_all(1, $sformatf("fx.idle%0d", r), 1'b0, 4'h0, '0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
         tick();
         drive(1'b1, 1'b1, 4'h3, 1'b1, 32'h0 + r);
         @(negedge clk);
         cmp_all(1, $sformatf("fx.gnt%0d", r), 1'b1, 4'h3, A1, D1, 0, 0, 32'h0, 1, 0, 32'h0 + r);
         tick();
         drive(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);
         @(negedge clk);
         cmp_all(1, $sformatf("fx.gap%0d", r), 1'b0, 4'h0, '0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
         tick();
      end
      @(negedge clk);
      cmp_all(1, "fx.idle_m0", 1'b0, 4'h0, '0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 4'h0, 1'b1, 32'h0F0F0F0F);
      @(negedge clk);
      cmp_all(1, "fx.gnt_m0", 1'b1, 4'h0, A0, D0, 1, 0, 32'h0F0F0F0F, 0, 0, 32'h0);
      tick();

      run_random(0, 1500);
      run_random(1, 1500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
